ctrl_multiciclo: RTL and testbench

Main control state machine for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives every datapath mux and write enable. Produces the 3-bit `AluOp` consumed directly by the ALU control decoder downstream, which combines it with `func` to select the ALU operation.

---
 rtl/ctrl_multiciclo_if.sv | 31 +++
 rtl/ctrl_multiciclo.sv | 82 ++++++++
 tb/tb_ctrl_multiciclo.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ctrl_multiciclo_if.sv
// ctrl_multiciclo_if: instruction fields in, datapath control signals out of the multicycle controller
interface ctrl_multiciclo_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] pc_source;
  logic [2:0] AluOp;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal;
  modport master (
    input  opcode, func, zero,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, pc_source, AluOp, state, instr_done, illegal
  );
  modport slave (
    output opcode, func, zero,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, pc_source, AluOp, state, instr_done, illegal
  );
endinterface

// File: rtl/ctrl_multiciclo.sv
// ctrl_multiciclo: main control FSM sequencing the multicycle MIPS datapath
module ctrl_multiciclo (
  input logic clk,
  input logic rst_n,
  ctrl_multiciclo_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB,
    BRANCH, JUMP, I_EXEC, I_WB, JAL, JR, S14, S15
  } state_t;
  state_t state, nxt;
  logic pc_w, ir_w, mw, rw, mr, iod, done, ill;
  logic [1:0] rd, m2r, sa, ps;
  logic [2:0] sb, ao;
  logic is_lui, is_logic;
  assign is_lui   = bus.opcode == 6'b001111;
  assign is_logic = bus.opcode inside {6'b001100, 6'b001101, 6'b001110};
  always_ff @(posedge clk)
    if (!rst_n) state <= FETCH;
    else state <= nxt;
  always_comb begin
    nxt = FETCH; pc_w = 1'b0; ir_w = 1'b0; mw = 1'b0; rw = 1'b0; mr = 1'b0; iod = 1'b0;
    done = 1'b0; ill = 1'b0; rd = 2'b00; m2r = 2'b00; sa = 2'b00; ps = 2'b00; sb = 3'b000; ao = 3'b000;
    case (state)
      FETCH:    begin mr = 1'b1; ir_w = 1'b1; sb = 3'b001; pc_w = 1'b1; nxt = DECODE; end
      DECODE: begin
        sb = 3'b011;
        case (bus.opcode)
          6'b000000: nxt = (bus.func == 6'b001000) ? JR : R_EXEC;
          6'b100011, 6'b101011: nxt = MEM_ADDR;
          6'b000100, 6'b000101: nxt = BRANCH;
          6'b000010: nxt = JUMP;
          6'b000011: nxt = JAL;
          6'b001000, 6'b001010, 6'b001011, 6'b001100,
          6'b001101, 6'b001110, 6'b001111: nxt = I_EXEC;
          default: ill = 1'b1;
        endcase
      end
      MEM_ADDR: begin sa = 2'b01; sb = 3'b010; nxt = (bus.opcode == 6'b101011) ? MEM_WR : MEM_RD; end
      MEM_RD:   begin mr = 1'b1; iod = 1'b1; nxt = MEM_WB; end
      MEM_WB:   begin rw = 1'b1; m2r = 2'b01; done = 1'b1; end
      MEM_WR:   begin mw = 1'b1; iod = 1'b1; done = 1'b1; end
      R_EXEC:   begin sa = 2'b01; ao = 3'b110; nxt = R_WB; end
      R_WB:     begin rw = 1'b1; rd = 2'b01; done = 1'b1; end
      // beq takes the branch on zero, bne on not-zero
      BRANCH: begin
        sa = 2'b01; ao = 3'b001; ps = 2'b01; done = 1'b1;
        pc_w = (bus.opcode == 6'b000101) ? ~bus.zero : bus.zero;
      end
      JUMP:     begin ps = 2'b10; pc_w = 1'b1; done = 1'b1; end
      I_EXEC: begin
        sa = is_lui ? 2'b10 : 2'b01;
        sb = is_lui ? 3'b101 : is_logic ? 3'b100 : 3'b010;
        ao = (bus.opcode == 6'b001100) ? 3'b010 :
             (bus.opcode == 6'b001101) ? 3'b011 :
             (bus.opcode == 6'b001110) ? 3'b100 :
             (bus.opcode inside {6'b001010, 6'b001011}) ? 3'b101 : 3'b000;
        nxt = I_WB;
      end
      I_WB:     begin rw = 1'b1; done = 1'b1; end
      JAL:      begin rw = 1'b1; rd = 2'b10; m2r = 2'b10; ps = 2'b10; pc_w = 1'b1; done = 1'b1; end
      JR:       begin ps = 2'b11; pc_w = 1'b1; done = 1'b1; end
      default:  nxt = FETCH;
    endcase
  end
  // reset presents FETCH decoding, so write enables must be masked
  assign bus.pc_write   = pc_w & rst_n;
  assign bus.ir_write   = ir_w & rst_n;
  assign bus.mem_write  = mw & rst_n;
  assign bus.reg_write  = rw & rst_n;
  assign bus.mem_read   = mr;
  assign bus.i_or_d     = iod;
  assign bus.reg_dst    = rd;
  assign bus.mem_to_reg = m2r;
  assign bus.alu_src_a  = sa;
  assign bus.alu_src_b  = sb;
  assign bus.pc_source  = ps;
  assign bus.AluOp      = ao;
  assign bus.state      = state;
  assign bus.instr_done = done;
  assign bus.illegal    = ill;
endmodule

// File: tb/tb_ctrl_multiciclo.sv
// tb_ctrl_multiciclo: directed and random instruction streams checked against an instruction-level model
module tb_ctrl_multiciclo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4, C_J = 5, C_JAL = 6, C_JR = 7, C_ILL = 8;
  ctrl_multiciclo_if bus_if ();
  ctrl_multiciclo dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int cat_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b001000) ? C_JR : C_R;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100, 6'b000101: return C_BR;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      6'b001000, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b001111: return C_I;
      default: return C_ILL;
    endcase
  endfunction
  // I-type ALU function by opcode: {AluOp, src_a, src_b}
  function automatic logic [7:0] itab(input logic [5:0] op);
    case (op)
      6'b001010, 6'b001011: return {3'd5, 2'd1, 3'd2};
      6'b001100: return {3'd2, 2'd1, 3'd4};
      6'b001101: return {3'd3, 2'd1, 3'd4};
      6'b001110: return {3'd4, 2'd1, 3'd4};
      6'b001111: return {3'd0, 2'd2, 3'd5};
      default:   return {3'd0, 2'd1, 3'd2};
    endcase
  endfunction
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
    int c, l, st;
    int path[$];
    logic ex, lst, wr;
    logic [1:0] e_sa, e_ps;
    logic [2:0] e_sb, e_ao;
    logic e_pw;
    c = cat_of(op, fn);
    path = '{0, 1};
    case (c)
      C_LW:  path = {path, 2, 3, 4};
      C_SW:  path = {path, 2, 5};
      C_R:   path = {path, 6, 7};
      C_I:   path = {path, 10, 11};
      C_BR:  path.push_back(8);
      C_J:   path.push_back(9);
      C_JAL: path.push_back(12);
      C_JR:  path.push_back(13);
      default: ;
    endcase
    l = path.size();
    bus_if.opcode = op;
    bus_if.func = fn;
    for (int i = 0; i < l; i++) begin
      bus_if.zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      st = path[i];
      ex = (i == 2);
      lst = (i == l - 1) && (c != C_ILL);
      wr = lst && (c inside {C_LW, C_R, C_I, C_JAL});
      e_ao = !ex ? 3'd0 : (c == C_R) ? 3'd6 : (c == C_BR) ? 3'd1 : (c == C_I) ? itab(op)[7:5] : 3'd0;
      e_sa = (ex && c inside {C_LW, C_SW, C_R, C_BR}) ? 2'd1 : (ex && c == C_I) ? itab(op)[4:3] : 2'd0;
      e_sb = (i == 0) ? 3'd1 : (i == 1) ? 3'd3 : (ex && c inside {C_LW, C_SW}) ? 3'd2 :
             (ex && c == C_I) ? itab(op)[2:0] : 3'd0;
      e_ps = !ex ? 2'd0 : (c == C_BR) ? 2'd1 : (c inside {C_J, C_JAL}) ? 2'd2 : (c == C_JR) ? 2'd3 : 2'd0;
      e_pw = (i == 0) || (ex && c inside {C_J, C_JAL, C_JR}) ||
             (ex && c == C_BR && ((op == 6'b000101) ? !bus_if.zero : bus_if.zero));
      chk("state", bus_if.state, st);
      chk("instr_done", bus_if.instr_done, lst);
      chk("illegal", bus_if.illegal, (c == C_ILL) && i == 1);
      chk("ir_write", bus_if.ir_write, i == 0);
      chk("mem_read", bus_if.mem_read, i == 0 || (c == C_LW && i == 3));
      chk("mem_write", bus_if.mem_write, c == C_SW && i == 3);
      chk("i_or_d", bus_if.i_or_d, c inside {C_LW, C_SW} && i == 3);
      chk("reg_write", bus_if.reg_write, wr);
      chk("reg_dst", bus_if.reg_dst, !wr ? 0 : (c == C_R) ? 1 : (c == C_JAL) ? 2 : 0);
      chk("mem_to_reg", bus_if.mem_to_reg, !wr ? 0 : (c == C_LW) ? 1 : (c == C_JAL) ? 2 : 0);
      chk("pc_write", bus_if.pc_write, e_pw);
      chk("pc_source", bus_if.pc_source, e_ps);
      chk("AluOp", bus_if.AluOp, e_ao);
      chk("alu_src_a", bus_if.alu_src_a, e_sa);
      chk("alu_src_b", bus_if.alu_src_b, e_sb);
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    logic [5:0] ops [15];
    ops = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011,
            6'b001000, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
    bus_if.opcode = 6'b0;
    bus_if.func = 6'b0;
    bus_if.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", bus_if.state, 0);
    chk("rst_pc_write", bus_if.pc_write, 0);
    chk("rst_ir_write", bus_if.ir_write, 0);
    chk("rst_mem_read", bus_if.mem_read, 1);
    rst_n = 1'b1;
    run_instr(6'b100011, 6'b0, -1);
    run_instr(6'b000000, 6'b100000, -1);
    run_instr(6'b000100, 6'b0, 1);
    run_instr(6'b000100, 6'b0, 0);
    run_instr(6'b000101, 6'b0, 0);
    run_instr(6'b000101, 6'b0, 1);
    for (int k = 8; k < 16; k++) run_instr(6'(k), 6'b0, -1);
    run_instr(6'b000011, 6'b0, -1);
    run_instr(6'b000000, 6'b001000, -1);
    run_instr(6'b000010, 6'b0, -1);
    run_instr(6'b101011, 6'b0, -1);
    run_instr(6'b111111, 6'b0, -1);
    for (int n = 0; n < 300; n++) begin
      int idx;
      logic [5:0] fn;
      idx = $urandom_range(0, 17);
      fn = ($urandom_range(0, 2) == 0) ? 6'b001000 : 6'($urandom);
      run_instr(idx < 15 ? ops[idx] : 6'($urandom), fn, -1);
    end
    // abort a lw in its memory-read cycle
    bus_if.opcode = 6'b100011;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("abort_pre_state", bus_if.state, 3);
    rst_n = 1'b0;
    #1;
    chk("abort_pc_write", bus_if.pc_write, 0);
    chk("abort_ir_write", bus_if.ir_write, 0);
    chk("abort_mem_write", bus_if.mem_write, 0);
    chk("abort_reg_write", bus_if.reg_write, 0);
    @(posedge clk);
    #1;
    chk("abort_state", bus_if.state, 0);
    chk("abort_rst_pc_write", bus_if.pc_write, 0);
    chk("abort_rst_ir_write", bus_if.ir_write, 0);
    rst_n = 1'b1;
    run_instr(6'b100011, 6'b0, -1);
    run_instr(6'b000000, 6'b100010, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
